// File: rtl/pixq_pkg.sv
// pixq_pkg: shared types and helpers for the pixel reorder queue.
//   pixel_t   - one finished pixel {colour, x, y} in the default layout
//               (24-bit colour, 10-bit coordinates).
//   ptr_width - FIFO pointer width: index bits plus one wrap bit.
package pixq_pkg;

  localparam int PIX_DATA_WIDTH = 10;
  localparam int PIX_RGB_SIZE   = 24;

  typedef struct packed {
    logic [PIX_RGB_SIZE-1:0]   colour;
    logic [PIX_DATA_WIDTH-1:0] x;
    logic [PIX_DATA_WIDTH-1:0] y;
  } pixel_t;

  // The extra wrap bit lets full and empty be told apart with all
  // DEPTH slots in use.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pixq_fifo.sv
// pixq_fifo: one per-engine pixel FIFO of the reorder queue.
//   clk, reset        - clock, synchronous active-high reset
//   wr_valid_i        - write request; stored when !full_o
//   wr_colour_i/x_i/y_i - pixel to store
//   wr_ready_o        - !full_o, from registered pointers only
//   rd_en_i           - pop the head (caller guarantees non-empty)
//   rd_colour_o/x_o/y_o - current head, combinational from storage
//   empty_o, full_o   - occupancy flags
// Macro PIXEL_REORDER_DEDUP_EN: drop a write whose (x, y) repeats the
// last stored one; wr_ready_o is not affected by the drop.
module pixq_fifo
  import pixq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 10,
  parameter int RGB_SIZE   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid_i,
  input  logic [RGB_SIZE-1:0]   wr_colour_i,
  input  logic [DATA_WIDTH-1:0] wr_x_i,
  input  logic [DATA_WIDTH-1:0] wr_y_i,
  output logic                  wr_ready_o,
  input  logic                  rd_en_i,
  output logic [RGB_SIZE-1:0]   rd_colour_o,
  output logic [DATA_WIDTH-1:0] rd_x_o,
  output logic [DATA_WIDTH-1:0] rd_y_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PW   = ptr_width(DEPTH);
  localparam int AW   = PW - 1;
  localparam int XY_W = 2 * DATA_WIDTH;
  localparam int W    = RGB_SIZE + XY_W;

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [XY_W-1:0] wr_xy;
  logic            push;

  assign wr_xy      = {wr_x_i, wr_y_i};
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_ready_o = !full_o;

`ifdef PIXEL_REORDER_DEDUP_EN
  logic [XY_W-1:0] last_xy_q, last_xy_d;

  // All-ones is outside any real frame, so the first pixel is never dropped.
  assign push = wr_valid_i && !full_o && (wr_xy != last_xy_q);

  // NOTE: every signal driven in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    last_xy_d = last_xy_q;
    if (push) last_xy_d = wr_xy;
  end

  always_ff @(posedge clk) begin
    if (reset) last_xy_q <= '1;
    else       last_xy_q <= last_xy_d;
  end
`else
  assign push = wr_valid_i && !full_o;
`endif

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_en_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide what is valid,
  // which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {wr_colour_i, wr_xy};
  end

  assign {rd_colour_o, rd_x_o, rd_y_o} = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pixel_reorder_queue.sv
// pixel_reorder_queue: collects finished pixels from NUM_CH render engines
// (one FIFO each) and emits them on one valid/ready stream in raster order.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - per-channel write handshake; in_ready low = full
//   in_colour/in_x/in_y - per-channel pixel, channel c at [c*W +: W]
//   out_valid/out_ready - output handshake
//   out_colour/out_x/out_y - held output pixel
//   out_last            - high with pixel (X_MAX, Y_MAX)
//   stall_err           - sticky: all channels full and no head matches
// Macro PIXEL_REORDER_DEDUP_EN enables duplicate-write dropping per channel.
module pixel_reorder_queue
  import pixq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 10,
  parameter int RGB_SIZE   = 24,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*RGB_SIZE-1:0]   in_colour,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_x,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RGB_SIZE-1:0]          out_colour,
  output logic [DATA_WIDTH-1:0]        out_x,
  output logic [DATA_WIDTH-1:0]        out_y,
  output logic                         out_last,
  output logic                         stall_err
);

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_MAX);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_MAX);

  logic [NUM_CH-1:0]     empty, full, match, grant, pop;
  logic [RGB_SIZE-1:0]   head_colour [NUM_CH];
  logic [DATA_WIDTH-1:0] head_x [NUM_CH];
  logic [DATA_WIDTH-1:0] head_y [NUM_CH];

  logic [DATA_WIDTH-1:0] exp_x_q, exp_x_d, exp_y_q, exp_y_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [RGB_SIZE-1:0]   out_colour_q, out_colour_d, sel_colour;
  logic [DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, sel_x, sel_y;
  logic                  stall_err_q, stall_err_d;
  logic                  any_match, load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pixq_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RGB_SIZE   (RGB_SIZE)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr_valid_i  (in_valid[c]),
      .wr_colour_i (in_colour[c*RGB_SIZE +: RGB_SIZE]),
      .wr_x_i      (in_x[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_y_i      (in_y[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_ready_o  (in_ready[c]),
      .rd_en_i     (pop[c]),
      .rd_colour_o (head_colour[c]),
      .rd_x_o      (head_x[c]),
      .rd_y_o      (head_y[c]),
      .empty_o     (empty[c]),
      .full_o      (full[c])
    );

    assign match[c] = !empty[c] && (head_x[c] == exp_x_q) && (head_y[c] == exp_y_q);
  end

  // Isolate the lowest set bit: the lowest-index matching channel wins.
  assign grant     = match & (~match + NUM_CH'(1));
  assign any_match = |match;
  assign load      = any_match && (!out_valid_q || out_ready);
  assign pop       = load ? grant : '0;

  always_comb begin
    sel_colour = '0;
    sel_x      = '0;
    sel_y      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_colour = head_colour[c];
        sel_x      = head_x[c];
        sel_y      = head_y[c];
      end
    end
  end

  always_comb begin
    exp_x_d      = exp_x_q;
    exp_y_d      = exp_y_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_colour_d = out_colour_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    stall_err_d  = stall_err_q || (&full && !any_match);
    if (load) begin
      out_valid_d  = 1'b1;
      out_colour_d = sel_colour;
      out_x_d      = sel_x;
      out_y_d      = sel_y;
      out_last_d   = (exp_x_q == X_LAST) && (exp_y_q == Y_LAST);
      if (exp_x_q == X_LAST) begin
        exp_x_d = '0;
        exp_y_d = (exp_y_q == Y_LAST) ? '0 : exp_y_q + 1'b1;
      end else begin
        exp_x_d = exp_x_q + 1'b1;
      end
    end else if (out_ready) begin
      // Held beat accepted with nothing to replace it.
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_x_q      <= '0;
      exp_y_q      <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_colour_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      exp_x_q      <= exp_x_d;
      exp_y_q      <= exp_y_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_colour_q <= out_colour_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_colour = out_colour_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_pixel_reorder_queue.sv
// Self-checking bench for pixel_reorder_queue. A queue-based model tracks
// per-channel contents, the expected raster position and the output beat;
// it is compared against the DUT every cycle, and directed literal checks
// pin the model. A small frame (X_MAX=7, Y_MAX=2) keeps frame wrap short.
module tb_pixel_reorder_queue;
  import pixq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int DW     = 10;
  localparam int RGB    = 24;
  localparam int XM     = 7;
  localparam int YM     = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_CH-1:0]     in_valid, in_ready;
  logic [NUM_CH*RGB-1:0] in_colour;
  logic [NUM_CH*DW-1:0]  in_x, in_y;
  logic                  out_valid, out_ready, out_last, stall_err;
  logic [RGB-1:0]        out_colour;
  logic [DW-1:0]         out_x, out_y;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int beats_before;

  always #5 clk = ~clk;

  pixel_reorder_queue #(
    .NUM_CH (NUM_CH), .DEPTH (DEPTH), .DATA_WIDTH (DW), .RGB_SIZE (RGB),
    .X_MAX (XM), .Y_MAX (YM)
  ) dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_colour (in_colour), .in_x (in_x), .in_y (in_y),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_colour (out_colour), .out_x (out_x), .out_y (out_y),
    .out_last (out_last), .stall_err (stall_err)
  );

  function automatic logic [RGB-1:0] colour_of(input int x, input int y);
    logic [DW-1:0] xv, yv;
    xv = DW'(x);
    yv = DW'(y);
    return {4'hA, xv, yv};
  endfunction

  // ---------------- behavioural model ----------------
  pixel_t        mq [NUM_CH][$];
  logic [2*DW-1:0] m_last_xy [NUM_CH];
  pixel_t        m_out, m_p;
  bit            m_ov, m_lst, m_stall, m_full_all;
  bit            m_rdy [NUM_CH];
  int            m_ex, m_ey, m_win;

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        m_last_xy[c] = '1;
      end
      m_ov = 0; m_lst = 0; m_out = '0; m_stall = 0; m_ex = 0; m_ey = 0;
    end else begin
      m_win = -1;
      m_full_all = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_rdy[c] = mq[c].size() < DEPTH;
        if (m_rdy[c]) m_full_all = 0;
        if (m_win < 0 && mq[c].size() > 0 && int'(mq[c][0].x) == m_ex &&
            int'(mq[c][0].y) == m_ey)
          m_win = c;
      end
      if (m_full_all && m_win < 0) m_stall = 1;
      if (m_win >= 0 && (!m_ov || out_ready)) begin
        m_out = mq[m_win].pop_front();
        m_ov  = 1;
        m_lst = (m_ex == XM && m_ey == YM);
        if (m_ex == XM) begin
          m_ex = 0;
          m_ey = (m_ey == YM) ? 0 : m_ey + 1;
        end else begin
          m_ex = m_ex + 1;
        end
      end else if (out_ready) begin
        m_ov  = 0;
        m_lst = 0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[c] && m_rdy[c]) begin
          m_p.colour = in_colour[c*RGB +: RGB];
          m_p.x      = in_x[c*DW +: DW];
          m_p.y      = in_y[c*DW +: DW];
`ifdef PIXEL_REORDER_DEDUP_EN
          if ({m_p.x, m_p.y} != m_last_xy[c]) begin
            mq[c].push_back(m_p);
            m_last_xy[c] = {m_p.x, m_p.y};
          end
`else
          mq[c].push_back(m_p);
`endif
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = mq[c].size() < DEPTH;
    check("m_in_ready", in_ready, r);
    check("m_out_valid", out_valid, m_ov);
    check("m_out_last", out_last, m_lst);
    check("m_stall_err", stall_err, m_stall);
    if (m_ov) begin
      check("m_out_x", out_x, m_out.x);
      check("m_out_y", out_y, m_out.y);
      check("m_out_colour", out_colour, m_out.colour);
    end
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      compare_model();
      if (out_valid && out_ready) beats++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input int x, input int y);
    in_valid[c]               = 1'b1;
    in_x[c*DW +: DW]          = DW'(x);
    in_y[c*DW +: DW]          = DW'(y);
    in_colour[c*RGB +: RGB]   = colour_of(x, y);
  endtask

  task automatic clear_in();
    in_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_colour = '0; in_x = '0; in_y = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_stall_err", stall_err, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_x", out_x, 0);

    // Single channel, 1-cycle latency.
    drive(0, 0, 0); tick();
    check("t1_valid0", out_valid, 0);
    drive(0, 1, 0); tick();
    check("t1_v1", out_valid, 1); check("t1_x1", out_x, 0);
    drive(0, 2, 0); tick();
    check("t1_x2", out_x, 1);
    clear_in(); tick();
    check("t1_x3", out_x, 2); check("t1_col3", out_colour, 24'hA00800);
    tick();
    check("t1_drained", out_valid, 0);

    // Four channels round-robin, one pixel per cycle, no gaps.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      clear_in();
      if (k < 8) drive(k % NUM_CH, k, 0);
      tick();
      if (k >= 1) begin
        check("t2_valid", out_valid, 1);
        check("t2_x", out_x, k - 1);
      end
    end
    clear_in(); tick();

    // Out-of-order arrival: (1,0) waits for (0,0).
    do_reset();
    drive(1, 1, 0); tick();
    clear_in(); tick();
    drive(0, 0, 0); tick();
    check("t3_wait", out_valid, 0);
    clear_in(); tick();
    check("t3_first_x", out_x, 0); check("t3_first_v", out_valid, 1);
    tick();
    check("t3_second_x", out_x, 1); check("t3_second_v", out_valid, 1);
    tick();
    check("t3_drained", out_valid, 0);

    // Fill channel 0, backpressure, pop one, mid-frame reset.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 7) drive(0, k + 1, 0); else drive(0, 0, 1);
      tick();
    end
    clear_in();
    check("t4_full0", in_ready, 4'b1110);
    drive(1, 0, 0); tick();
    clear_in(); tick();
    check("t4_held_v", out_valid, 1); check("t4_held_x", out_x, 0);
    tick();
    check("t4_hold_x", out_x, 0); check("t4_still_full", in_ready, 4'b1110);
    out_ready = 1'b1; tick();
    check("t4_pop_ready", in_ready, 4'hF); check("t4_pop_x", out_x, 1);
    out_ready = 1'b0; tick();
    do_reset();
    check("t4_rst_valid", out_valid, 0); check("t4_rst_ready", in_ready, 4'hF);
    out_ready = 1'b1;
    drive(3, 0, 0); tick();
    clear_in(); tick();
    check("t4_restart_v", out_valid, 1); check("t4_restart_x", out_x, 0);
    check("t4_restart_y", out_y, 0);
    tick();

    // All channels full with no match: sticky stall_err.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < NUM_CH; c++) drive(c, k, 1);
      tick();
    end
    clear_in();
    check("t5_all_full", in_ready, 4'h0);
    check("t5_stall_not_yet", stall_err, 0);
    tick();
    check("t5_stall_set", stall_err, 1);
    tick();
    check("t5_stall_sticky", stall_err, 1);
    do_reset();
    check("t5_stall_rst", stall_err, 0);
    out_ready = 1'b1;

    // Full frame plus one: out_last on (XM, YM) only, then (0,0).
    for (int k = 0; k < 26; k++) begin
      clear_in();
      if (k < 25) drive(k % NUM_CH, k % 8, (k / 8) % 3);
      tick();
      if (k >= 1) begin
        check("t6_last", out_last, (k - 1 == 23));
        if (k - 1 == 23) begin
          check("t6_last_x", out_x, 7); check("t6_last_y", out_y, 2);
        end
        if (k - 1 == 24) begin
          check("t6_wrap_x", out_x, 0); check("t6_wrap_y", out_y, 0);
        end
      end
    end
    clear_in(); tick();

    // Toggling out_ready: every written pixel is accepted exactly once.
    do_reset();
    beats_before = beats;
    for (int k = 0; k < 20; k++) begin
      clear_in();
      if (k < 16) drive(k % NUM_CH, k % 8, k / 8);
      out_ready = (k % 3 != 0);
      tick();
    end
    clear_in();
    out_ready = 1'b1;
    repeat (20) tick();
    check("t7_beats", beats - beats_before, 16);

    // Held in_valid for three cycles on the same pixel.
    do_reset();
    drive(2, 5, 0); tick(); tick(); tick();
    clear_in();
    for (int k = 0; k < 5; k++) begin
      drive(2, k, 1); tick();
    end
    clear_in(); tick();
`ifdef PIXEL_REORDER_DEDUP_EN
    check("t8_dedup_room", in_ready[2], 1);
`else
    check("t8_dup_full", in_ready[2], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
